// File: rtl/sb_arm_pkg.sv
// Shared definitions for the pick/place task sequencer: opcodes, response
// status codes, arm handshake codes and the sequencer state encoding.
package sb_arm_pkg;

    // Requester opcode bit
    localparam logic OP_PICK  = 1'b0;
    localparam logic OP_PLACE = 1'b1;

    // Response status codes
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_REJECT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_BAD_DONE = 2'b11;

    // Completion codes reported by the arm block
    localparam logic [1:0] DONE_NONE  = 2'd0;
    localparam logic [1:0] DONE_PICK  = 2'd1;
    localparam logic [1:0] DONE_PLACE = 2'd2;

    // Movement selectors understood by the arm block
    localparam logic [5:0] MOV_PICK  = 6'd0;
    localparam logic [5:0] MOV_PLACE = 6'd1;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RELEASE   = 3'd4,
        S_REJ       = 3'd5
    } seq_state_t;

    // Movement code driven to the arm for a given opcode
    function automatic logic [5:0] op_movement(input logic op);
        return (op == OP_PLACE) ? MOV_PLACE : MOV_PICK;
    endfunction

    // Completion code the arm reports when it finishes the given opcode
    function automatic logic [1:0] op_done_code(input logic op);
        return (op == OP_PLACE) ? DONE_PLACE : DONE_PICK;
    endfunction

endpackage

// File: rtl/sb_rr_arb2.sv
// Two-way round-robin arbiter. gnt is a combinational one-hot pick from the
// current requests; the pointer flop remembers which requester to favour
// when both ask at once and is moved only when the caller accepts a grant.
module sb_rr_arb2
    import sb_arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Requester favoured on a tie; starts at requester 0.
    logic ptr_reg;

    // A lone requester always wins; on a tie the pointer decides.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] && (!req[1 - gi] || (ptr_reg == 1'(gi)));
        end
    endgenerate

    // After a grant, favour the requester that did not win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (advance && (|gnt)) begin
            ptr_reg <= ~gnt[1];
        end
    end

endmodule

// File: rtl/sb_arm_task_sequencer.sv
// Pick/place task sequencer. Accepts one request at a time from two
// requesters, checks it against the gripper state, drives the shared arm
// block through start/movement/done, guards it with a watchdog and returns
// exactly one status pulse per accepted request.
module sb_arm_task_sequencer
    import sb_arm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 400_000_000,
    parameter int unsigned GAP_CYC     = 1000,
    parameter int unsigned CNT_W       = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_op,
    output logic [1:0] req_ready,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [1:0] resp_status,
    output logic       arm_start,
    output logic [5:0] arm_movement,
    input  logic [1:0] arm_done,
    output logic       holding,
    output logic       busy,
    output logic       fault
);

    // Last counter values before leaving WAIT_DONE on timeout / RELEASE
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    seq_state_t       state_reg;
    logic             id_reg;
    logic             op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       req_ready_reg;
    logic             resp_valid_reg;
    logic             resp_id_reg;
    logic [1:0]       resp_status_reg;
    logic             arm_start_reg;
    logic [5:0]       arm_movement_reg;
    logic             holding_reg;
    logic             fault_reg;

    logic [1:0]       gnt;
    logic             advance;
    logic             grant_op;
    logic             grant_legal;

    // The pointer moves whenever IDLE hands out a grant.
    assign advance = (state_reg == S_IDLE) && (|req_valid);

    sb_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .gnt     (gnt)
    );

    // Opcode of the granted requester during the ready cycle, and whether
    // the gripper state allows it.
    assign grant_op    = req_op[id_reg];
    assign grant_legal = !fault_reg &&
                         (((grant_op == OP_PICK) && !holding_reg) ||
                          ((grant_op == OP_PLACE) && holding_reg));

    // Sequencer FSM with the shared watchdog / release-gap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            id_reg           <= 1'b0;
            op_reg           <= OP_PICK;
            cnt_reg          <= '0;
            req_ready_reg    <= 2'b00;
            resp_valid_reg   <= 1'b0;
            resp_id_reg      <= 1'b0;
            resp_status_reg  <= ST_OK;
            arm_start_reg    <= 1'b0;
            arm_movement_reg <= MOV_PICK;
            holding_reg      <= 1'b0;
            fault_reg        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            req_ready_reg  <= 2'b00;
            resp_valid_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (|req_valid) begin
                        req_ready_reg <= gnt;
                        id_reg        <= gnt[1];
                        state_reg     <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    // req_ready is visible now; transfer only if still valid.
                    if (req_valid[id_reg]) begin
                        op_reg    <= grant_op;
                        state_reg <= grant_legal ? S_ISSUE : S_REJ;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_REJ: begin
                    resp_valid_reg  <= 1'b1;
                    resp_id_reg     <= id_reg;
                    resp_status_reg <= ST_REJECT;
                    state_reg       <= S_IDLE;
                end

                S_ISSUE: begin
                    arm_movement_reg <= op_movement(op_reg);
                    arm_start_reg    <= 1'b1;
                    cnt_reg          <= '0;
                    state_reg        <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                    // Matching done is tested first so it beats a same-cycle timeout.
                    if (arm_done == op_done_code(op_reg)) begin
                        resp_status_reg <= ST_OK;
                        holding_reg     <= (op_reg == OP_PICK);
                    end else if (arm_done != DONE_NONE) begin
                        resp_status_reg <= ST_BAD_DONE;
                        fault_reg       <= 1'b1;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        resp_status_reg <= ST_TIMEOUT;
                        fault_reg       <= 1'b1;
                    end
                    if ((arm_done != DONE_NONE) || (cnt_reg == TIMEOUT_LAST)) begin
                        resp_valid_reg <= 1'b1;
                        resp_id_reg    <= id_reg;
                        arm_start_reg  <= 1'b0;
                        cnt_reg        <= '0;
                        state_reg      <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    // Hold start low long enough for the arm to fall back to its first state.
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_reg;
    assign resp_valid   = resp_valid_reg;
    assign resp_id      = resp_id_reg;
    assign resp_status  = resp_status_reg;
    assign arm_start    = arm_start_reg;
    assign arm_movement = arm_movement_reg;
    assign holding      = holding_reg;
    assign fault        = fault_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sb_arm_task_sequencer.sv
// Bench for sb_arm_task_sequencer: directed scenarios plus a randomized run,
// with a behavioural arm block and a request-level reference model.
module tb_sb_arm_task_sequencer;
    import sb_arm_pkg::*;

    localparam int TO  = 100;
    localparam int GAP = 4;

    // Arm behaviour modes
    localparam int ARM_OK    = 0;
    localparam int ARM_STUCK = 1;
    localparam int ARM_WRONG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_op = 2'b00;
    logic [1:0] req_ready;
    logic       resp_valid;
    logic       resp_id;
    logic [1:0] resp_status;
    logic       arm_start;
    logic [5:0] arm_movement;
    logic [1:0] arm_done = 2'b00;
    logic       holding;
    logic       busy;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor records
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         cur_len = 0;
    int         high_len = 0;
    int         resp_pulses = 0;
    logic [5:0] mov_at_rise = 6'd0;
    logic       mov_changed = 1'b0;
    logic       prev_start = 1'b0;

    // Arm model controls
    int arm_mode = ARM_OK;
    int arm_delay = 1;
    int arm_cnt = 0;

    // Reference model state
    int   pref_m = 0;
    logic hold_m = 1'b0;
    logic fault_m = 1'b0;

    sb_arm_task_sequencer #(
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP),
        .CNT_W       (29)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_status  (resp_status),
        .arm_start    (arm_start),
        .arm_movement (arm_movement),
        .arm_done     (arm_done),
        .holding      (holding),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completion code the behavioural arm reports for a movement
    function automatic logic [1:0] arm_code(input logic [5:0] mv, input logic wrong);
        logic is_place;
        is_place = (mv == 6'd1);
        if (wrong) is_place = !is_place;
        return is_place ? 2'd2 : 2'd1;
    endfunction

    // Behavioural arm: reports done arm_delay cycles after start, holds it
    // until start drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_done <= 2'd0;
            arm_cnt  <= 0;
        end else if (!arm_start) begin
            arm_done <= 2'd0;
            arm_cnt  <= 0;
        end else begin
            arm_cnt <= arm_cnt + 1;
            if (arm_mode != ARM_STUCK && arm_cnt == arm_delay - 1)
                arm_done <= arm_code(arm_movement, arm_mode == ARM_WRONG);
        end
    end

    // Monitor: arm_start rises, high time, movement stability, response pulses.
    always @(negedge clk) begin
        if (arm_start && !prev_start) begin
            rise_cnt    = rise_cnt + 1;
            rise_cyc    = cyc;
            mov_at_rise = arm_movement;
            mov_changed = 1'b0;
            cur_len     = 1;
        end else if (arm_start) begin
            cur_len = cur_len + 1;
            if (arm_movement != mov_at_rise) mov_changed = 1'b1;
        end else if (prev_start) begin
            high_len = cur_len;
        end
        if (resp_valid) resp_pulses = resp_pulses + 1;
        prev_start = arm_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_arm_start", 32'(arm_start), 0);
        check("rst_arm_movement", 32'(arm_movement), 0);
        check("rst_holding", 32'(holding), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        rst = 1'b0;
        pref_m = 0;
        hold_m = 1'b0;
        fault_m = 1'b0;
        @(negedge clk);
    endtask

    // One request transaction from an idle sequencer to its return to IDLE.
    task automatic txn(input string tag, input logic [1:0] mask, input logic [1:0] ops,
                       input int mode, input int delay);
        int         exp_id, n, rise0, pulses0, rcyc;
        logic       op, legal;
        logic [1:0] exp_st, exp_rdy;

        arm_mode  = mode;
        arm_delay = delay;
        exp_id = (mask == 2'b11) ? pref_m : (mask[1] ? 1 : 0);
        op     = ops[exp_id];
        legal  = !fault_m && ((op == OP_PICK) ? !hold_m : hold_m);
        if (!legal)                 exp_st = ST_REJECT;
        else if (mode == ARM_OK)    exp_st = ST_OK;
        else if (mode == ARM_STUCK) exp_st = ST_TIMEOUT;
        else                        exp_st = ST_BAD_DONE;
        exp_rdy = (exp_id == 1) ? 2'b10 : 2'b01;

        rise0   = rise_cnt;
        pulses0 = resp_pulses;
        req_op    = ops;
        req_valid = mask;

        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        rcyc = cyc;
        @(negedge clk);
        req_valid[exp_id] = 1'b0;

        n = 0;
        while (resp_valid !== 1'b1 && n < TO + 60) begin @(negedge clk); n++; end
        #1;
        check({tag, "_resp_valid"}, 32'(resp_valid), 1);
        check({tag, "_resp_id"}, 32'(resp_id), 32'(exp_id));
        check({tag, "_resp_status"}, 32'(resp_status), 32'(exp_st));
        check({tag, "_arm_starts"}, 32'(rise_cnt - rise0), legal ? 1 : 0);

        if (legal) begin
            if (mode == ARM_OK) hold_m = (op == OP_PICK);
            else fault_m = 1'b1;
        end
        pref_m = 1 - exp_id;
        check({tag, "_holding"}, 32'(holding), 32'(hold_m));
        check({tag, "_fault"}, 32'(fault), 32'(fault_m));

        if (legal) begin
            check({tag, "_start_latency"}, 32'(rise_cyc - rcyc), 2);
            check({tag, "_movement"}, 32'(mov_at_rise), (op == OP_PLACE) ? 1 : 0);
            check({tag, "_mov_stable"}, 32'(mov_changed), 0);
            if (mode == ARM_STUCK) check({tag, "_timeout_len"}, 32'(high_len), TO);
            n = 0;
            while (busy && n < GAP + 20) begin n++; @(negedge clk); end
            #1;
            check({tag, "_release_gap"}, 32'(n), GAP);
            check({tag, "_one_resp"}, 32'(resp_pulses - pulses0), 1);
        end
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n, pulses0, rise0;
        logic [1:0] rmask;

        // 1/2: pick then place with a completing arm
        do_reset();
        txn("t1_pick", 2'b01, 2'b00, ARM_OK, 20);
        txn("t2_place", 2'b10, 2'b10, ARM_OK, int'($urandom_range(1, 30)));

        // 3: both requesters hold PICK from reset
        do_reset();
        txn("t3_a", 2'b11, 2'b00, ARM_OK, 12);
        txn("t3_b", 2'b11, 2'b00, ARM_OK, 12);
        txn("t3_c", 2'b11, 2'b00, ARM_OK, 12);

        // Randomized traffic with a well-behaved arm
        for (int i = 0; i < 12; i++) begin
            rmask = 2'($urandom_range(1, 3));
            txn("rnd", rmask, 2'($urandom_range(0, 3)), ARM_OK, int'($urandom_range(1, 30)));
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Request withdrawn while ready is showing: no transfer
        rise0 = rise_cnt;
        pulses0 = resp_pulses;
        req_op = 2'b00;
        req_valid = 2'b01;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
        #1;
        check("drop_no_resp", 32'(resp_pulses - pulses0), 0);
        check("drop_no_start", 32'(rise_cnt - rise0), 0);
        check("drop_idle", 32'(busy), 0);

        // 4: stuck arm times out, later place is rejected by the fault
        do_reset();
        txn("t4_timeout", 2'b01, 2'b00, ARM_STUCK, 1);
        txn("t4_place_rej", 2'b10, 2'b10, ARM_OK, 5);

        // 5: pick answered with a place completion
        do_reset();
        txn("t5_bad_done", 2'b01, 2'b00, ARM_WRONG, 8);

        // 6: reset in the middle of WAIT_DONE
        do_reset();
        txn("t6_pick", 2'b01, 2'b00, ARM_OK, 10);
        arm_mode = ARM_STUCK;
        req_op = 2'b01;
        req_valid = 2'b01;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (!arm_start && n < 20) begin @(negedge clk); n++; end
        check("t6_started", 32'(arm_start), 1);
        repeat (5) @(negedge clk);
        check("t6_hold_pre", 32'(holding), 1);
        pulses0 = resp_pulses;
        #1 rst = 1'b1;
        #1;
        check("t6_async_start", 32'(arm_start), 0);
        check("t6_async_holding", 32'(holding), 0);
        check("t6_async_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pref_m = 0;
        hold_m = 1'b0;
        fault_m = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_resp", 32'(resp_pulses - pulses0), 0);
        txn("t6_after", 2'b01, 2'b00, ARM_OK, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
